// File: rtl/down_counter.sv
// down_counter: programmable 4-bit synchronous down counter with parallel load,
// count enable and optional auto-reload. It is the companion to the 4-bit up
// counter and uses the same Q0..Q3 output pins.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset (clears count, reload, tc)
//   load           parallel-load strobe; loads D into count and reload registers
//   D0..D3         load value, D0 = LSB
//   en             count enable
//   mode           0 = one-shot (stop at 0), 1 = auto-reload from last load value
//   Q0..Q3         registered count, Q0 = LSB
//   zero           combinational, high while count == 0
//   tc             registered terminal-count pulse (high in the cycle Q first hits 0)
module down_counter (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic en,
  input  logic mode,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic zero,
  output logic tc
);

  logic [3:0] d_val;
  logic [3:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       tc_q, tc_d;

  assign d_val = {D3, D2, D1, D0};

  // Priority below reset: load > en > hold.
  always_comb begin
    q_d  = q_q;
    r_d  = r_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = d_val;
      r_d = d_val;
    end else if (en) begin
      if (q_q != 4'd0) begin
        q_d = q_q - 4'd1;
        // Only the decrement from 1 into 0 is a terminal count; a reload
        // out of 0 or sitting at 0 never pulses tc.
        tc_d = (q_q == 4'd1);
      end else if (mode) begin
        q_d = r_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q  <= 4'd0;
      r_q  <= 4'd0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      r_q  <= r_d;
      tc_q <= tc_d;
    end
  end

  assign {Q3, Q2, Q1, Q0} = q_q;
  assign zero             = (q_q == 4'd0);
  assign tc               = tc_q;

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

  logic clk = 1'b0;
  logic reset, load, en, mode;
  logic D0, D1, D2, D3;
  logic Q0, Q1, Q2, Q3, zero, tc;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: plain integers following the counting rules.
  int mq = 0, mr = 0, mtc = 0;

  down_counter dut (
    .clk(clk), .reset(reset), .load(load),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .en(en), .mode(mode),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
    .zero(zero), .tc(tc)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] qv();
    return {Q3, Q2, Q1, Q0};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input int d, input bit e, input bit m);
    if (r) begin
      mq = 0; mr = 0; mtc = 0;
    end else if (l) begin
      mq = d; mr = d; mtc = 0;
    end else if (e) begin
      mtc = (mq == 1) ? 1 : 0;
      if (mq > 0) mq = mq - 1;
      else if (m) mq = mr;
    end else begin
      mtc = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, check all outputs after the edge.
  task automatic step(input bit r, input bit l, input bit e, input bit m, input logic [3:0] d);
    reset = r; load = l; en = e; mode = m;
    {D3, D2, D1, D0} = d;
    @(posedge clk);
    model_edge(r, l, int'(d), e, m);
    #1;
    check("q",    qv(),        4'(mq));
    check("zero", {3'b0, zero}, (mq == 0) ? 4'd1 : 4'd0);
    check("tc",   {3'b0, tc},   4'(mtc));
  endtask

  initial begin
    int tc_cnt;
    int exp_os[8]  = '{5, 4, 3, 2, 1, 0, 0, 0};
    int exp_ar[10] = '{3, 2, 1, 0, 3, 2, 1, 0, 3, 2};
    int exp_en[5]  = '{7, 6, 6, 6, 5};
    bit en_pat[4]  = '{1, 0, 0, 1};

    reset = 0; load = 0; en = 0; mode = 0;
    {D3, D2, D1, D0} = 4'd0;
    @(negedge clk);

    // Reset held two cycles while load/en are active: no load happens.
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1, 0, 4'd9);
      check("rst_q",    qv(),         4'd0);
      check("rst_zero", {3'b0, zero}, 4'd1);
      check("rst_tc",   {3'b0, tc},   4'd0);
    end

    // One-shot count from 5.
    step(0, 1, 1, 0, 4'd5);
    check("os_q0", qv(), 4'(exp_os[0]));
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 1, 0, 4'd0);
      check("os_q",  qv(),       4'(exp_os[i]));
      check("os_tc", {3'b0, tc}, (i == 5) ? 4'd1 : 4'd0);
    end

    // Auto-reload from 3, period 4.
    step(0, 1, 1, 1, 4'd3);
    check("ar_q0", qv(), 4'(exp_ar[0]));
    for (int i = 1; i < 10; i++) begin
      step(0, 0, 1, 1, 4'd0);
      check("ar_q",  qv(),       4'(exp_ar[i]));
      check("ar_tc", {3'b0, tc}, (exp_ar[i] == 0) ? 4'd1 : 4'd0);
    end

    // Enable gating and load-over-enable priority.
    step(0, 1, 0, 0, 4'd7);
    check("en_q0", qv(), 4'(exp_en[0]));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, en_pat[i], 0, 4'd0);
      check("en_q", qv(), 4'(exp_en[i + 1]));
    end
    step(0, 1, 1, 0, 4'd12);
    check("ld_pri_q",  qv(),       4'd12);
    check("ld_pri_tc", {3'b0, tc}, 4'd0);

    // Load while Q == 1 with en high: no tc, Q takes D.
    step(0, 1, 0, 0, 4'd2);
    step(0, 0, 1, 0, 4'd0);
    check("ld1_pre", qv(), 4'd1);
    step(0, 1, 1, 0, 4'd9);
    check("ld1_q",  qv(),       4'd9);
    check("ld1_tc", {3'b0, tc}, 4'd0);

    // Reset mid-count in auto-reload clears the reload value too.
    step(0, 1, 0, 1, 4'd10);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 4'd0);
    check("mid_q7", qv(), 4'd7);
    step(1, 0, 1, 1, 4'd0);
    check("mid_rst_q", qv(), 4'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 1, 4'd0);
      check("mid_hold_q",  qv(),       4'd0);
      check("mid_hold_tc", {3'b0, tc}, 4'd0);
    end

    // Load 0 in one-shot: stays at 0, no tc.
    step(0, 1, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 4'd0);
      check("ld0_q",  qv(),       4'd0);
      check("ld0_tc", {3'b0, tc}, 4'd0);
    end

    // Load 15: exactly 15 enabled cycles to reach 0, single tc pulse.
    step(0, 1, 0, 0, 4'd15);
    tc_cnt = 0;
    for (int i = 1; i <= 18; i++) begin
      step(0, 0, 1, 0, 4'd0);
      if (tc === 1'b1) tc_cnt++;
      if (i == 14) check("f_q14", qv(), 4'd1);
      if (i == 15) check("f_q15", qv(), 4'd0);
    end
    check("f_tc_cnt", 4'(tc_cnt), 4'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
